// File: rtl/msg_streamer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : msg_streamer_pkg
// Purpose  : Shared definitions for the message streamer: the controller
//            state encoding (3 bits, IDLE=0 .. END=4) and the width helpers
//            used to size the slot-select and byte-count ports.
// Revision : 1.0 - initial release
// ============================================================================
package msg_streamer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_SEND = 3'd3,
    ST_END  = 3'd4
  } state_t;

  // Slot-select width: a single slot still needs a 1-bit port.
  function automatic int unsigned sel_width(input int unsigned nslots);
    return (nslots > 1) ? $clog2(nslots) : 1;
  endfunction

  // Index/count width: must hold the value SLOTLEN itself (full slot).
  function automatic int unsigned cnt_width(input int unsigned slotlen);
    return ($clog2(slotlen + 1) > 0) ? $clog2(slotlen + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/msg_streamer.sv
`default_nettype none
// ============================================================================
// Module   : msg_streamer
// Purpose  : Streams a NUL-terminated byte string out of one of NSLOTS
//            fixed-size slots of a synchronous-read memory (one-cycle read
//            latency) to a byte sink over a valid/ready handshake.
// Revision : 1.0 - initial release
//
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   start  in   start pulse, honoured only while idle
//   sel    in   slot to stream, latched on an accepted start (clamped)
//   maddr  out  memory read address = BASE + slot*SLOTLEN + idx
//   mdata  in   memory read data, valid one cycle after maddr is sampled
//   dout   out  byte to sink (registered)
//   oe     out  dout valid (registered)
//   rdy    in   sink ready; a transfer happens on oe & rdy
//   busy   out  high whenever the controller is not idle
//   done   out  one-cycle pulse at message end
//   count  out  bytes transferred in the current or last message
//   loop   in   repeat the message forever (only with MSG_STREAMER_LOOP_EN)
//
// Build option: define MSG_STREAMER_LOOP_EN to add the loop port.
// ============================================================================
module msg_streamer
  import msg_streamer_pkg::*;
#(
  parameter int WDATA   = 8,
  parameter int WADDR   = 19,
  parameter int NSLOTS  = 4,
  parameter int SLOTLEN = 256,
  parameter int BASE    = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [sel_width(NSLOTS)-1:0]    sel,
  output logic [WADDR-1:0]                maddr,
  input  logic [WDATA-1:0]                mdata,
  output logic [WDATA-1:0]                dout,
  output logic                            oe,
  input  logic                            rdy,
  output logic                            busy,
  output logic                            done,
  output logic [cnt_width(SLOTLEN)-1:0]   count
`ifdef MSG_STREAMER_LOOP_EN
  ,
  input  logic                            loop
`endif
);

  localparam int SW = sel_width(NSLOTS);
  localparam int CW = cnt_width(SLOTLEN);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NSLOTS - 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(SLOTLEN - 1);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] slot;
  logic [CW-1:0] idx;
  logic          xfer;
  logic          term;
  logic          repeat_msg;

  // oe is only ever high in SEND, so oe & rdy alone identifies a transfer.
  assign xfer = oe & rdy;
  assign term = (mdata == '0);

`ifdef MSG_STREAMER_LOOP_EN
  assign repeat_msg = loop;
`else
  assign repeat_msg = 1'b0;
`endif

  // Address is purely combinational from registered slot/idx, so it is
  // already stable during ADDR when the memory samples it.
  assign maddr = WADDR'(BASE) + WADDR'(slot) * WADDR'(SLOTLEN) + WADDR'(idx);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = ST_DATA;
      ST_DATA: state_nxt = term ? ST_END : ST_SEND;
      ST_SEND: begin
        // The last word of a full slot ends the message without a fetch.
        if (xfer) state_nxt = (idx == LAST_IDX) ? ST_END : ST_ADDR;
      end
      ST_END: begin
        done      = 1'b1;
        state_nxt = repeat_msg ? ST_ADDR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: slot, index, count and the registered sink interface
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot  <= '0;
      idx   <= '0;
      count <= '0;
      dout  <= '0;
      oe    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            slot  <= (int'(sel) > NSLOTS - 1) ? LAST_SLOT : sel;
            idx   <= '0;
            count <= '0;
          end
        end
        ST_DATA: begin
          if (!term) begin
            dout <= mdata;
            oe   <= 1'b1;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            oe    <= 1'b0;
            idx   <= idx + CW'(1);
            count <= count + CW'(1);
          end
        end
        ST_END: begin
          if (repeat_msg) begin
            idx   <= '0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_msg_streamer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_msg_streamer
// Purpose  : Self-checking bench for msg_streamer. Two instances: A with
//            4 slots x 256 words, B with 3 slots x 4 words (length limit and
//            slot clamping). Expected streams come from scanning the bench's
//            memory images for the first NUL within the slot.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msg_streamer;

  localparam int SLOTLEN_A = 256;
  localparam int NSLOTS_A  = 4;
  localparam int SLOTLEN_B = 4;
  localparam int NSLOTS_B  = 3;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  // ---------------- DUT A ----------------
  logic        start_a = 1'b0;
  logic [1:0]  sel_a = '0;
  logic [18:0] maddr_a;
  logic [7:0]  mdata_a = '0;
  logic [7:0]  dout_a;
  logic        oe_a, busy_a, done_a;
  logic        rdy_a = 1'b1;
  logic [8:0]  count_a;
  logic        loop_a = 1'b0;
  logic [7:0]  mem_a [0:NSLOTS_A*SLOTLEN_A-1];

  // ---------------- DUT B ----------------
  logic        start_b = 1'b0;
  logic [1:0]  sel_b = '0;
  logic [18:0] maddr_b;
  logic [7:0]  mdata_b = '0;
  logic [7:0]  dout_b;
  logic        oe_b, busy_b, done_b;
  logic        rdy_b = 1'b1;
  logic [2:0]  count_b;
  logic        loop_b = 1'b0;
  logic [7:0]  mem_b [0:NSLOTS_B*SLOTLEN_B-1];

  msg_streamer #(.WDATA(8), .WADDR(19), .NSLOTS(NSLOTS_A), .SLOTLEN(SLOTLEN_A), .BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .sel(sel_a), .maddr(maddr_a),
    .mdata(mdata_a), .dout(dout_a), .oe(oe_a), .rdy(rdy_a), .busy(busy_a),
    .done(done_a), .count(count_a)
`ifdef MSG_STREAMER_LOOP_EN
    , .loop(loop_a)
`endif
  );

  msg_streamer #(.WDATA(8), .WADDR(19), .NSLOTS(NSLOTS_B), .SLOTLEN(SLOTLEN_B), .BASE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .sel(sel_b), .maddr(maddr_b),
    .mdata(mdata_b), .dout(dout_b), .oe(oe_b), .rdy(rdy_b), .busy(busy_b),
    .done(done_b), .count(count_b)
`ifdef MSG_STREAMER_LOOP_EN
    , .loop(loop_b)
`endif
  );

  // Synchronous-read memories, one cycle of latency.
  always @(posedge clk) begin
    mdata_a <= mem_a[maddr_a[9:0]];
    mdata_b <= (int'(maddr_b) < NSLOTS_B*SLOTLEN_B) ? mem_b[maddr_b[3:0]] : 8'hEE;
  end

  // Sink ready: 0 = always high, 1 = random, 2 = held low.
  int rdy_mode_a = 0;
  int rdy_mode_b = 0;
  always @(posedge clk) begin
    #2;
    rdy_a = (rdy_mode_a == 0) ? 1'b1 : (rdy_mode_a == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    rdy_b = (rdy_mode_b == 0) ? 1'b1 : (rdy_mode_b == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  // Monitors: a transfer seen at negedge of cycle c completes at edge c+1.
  logic [7:0] got_a[$];
  int         addr_a[$];
  int         xcyc_a[$];
  int         dcyc_a[$];
  int         done_n_a = 0;
  bit         oe_seen_a = 0;
  logic [7:0] got_b[$];
  int         xcyc_b[$];
  int         done_n_b = 0;
  int         done_cyc_b = 0;
  int         maxaddr_b = -1;

  always @(negedge clk) begin
    if (oe_a && rdy_a) begin
      got_a.push_back(dout_a);
      addr_a.push_back(int'(maddr_a));
      xcyc_a.push_back(cyc);
    end
    if (done_a) begin
      done_n_a++;
      dcyc_a.push_back(cyc);
    end
    if (oe_a) oe_seen_a = 1;
    if (oe_b && rdy_b) begin
      got_b.push_back(dout_b);
      xcyc_b.push_back(cyc);
    end
    if (done_b) begin
      done_n_b++;
      done_cyc_b = cyc;
    end
    if (busy_b && !done_b && int'(maddr_b) > maxaddr_b) maxaddr_b = int'(maddr_b);
  end

  // Reference: the bytes of a slot up to (not including) the first NUL,
  // at most one slot long.
  function automatic bq_t ref_msg(input bit on_b, input int slot);
    bq_t q;
    int len = on_b ? SLOTLEN_B : SLOTLEN_A;
    logic [7:0] b;
    for (int k = 0; k < len; k++) begin
      b = on_b ? mem_b[slot*SLOTLEN_B + k] : mem_a[slot*SLOTLEN_A + k];
      if (b == 8'h00) break;
      q.push_back(b);
    end
    return q;
  endfunction

  task automatic clear_mon();
    got_a.delete(); addr_a.delete(); xcyc_a.delete(); dcyc_a.delete();
    done_n_a = 0; oe_seen_a = 0;
    got_b.delete(); xcyc_b.delete();
    done_n_b = 0; done_cyc_b = 0; maxaddr_b = -1;
  endtask

  // Returns the index of the edge that samples start.
  task automatic pulse_start_a(input logic [1:0] s, output int n);
    @(posedge clk); #1;
    start_a = 1'b1; sel_a = s;
    @(posedge clk); #1;
    n = cyc;
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b(input logic [1:0] s, output int n);
    @(posedge clk); #1;
    start_b = 1'b1; sel_b = s;
    @(posedge clk); #1;
    n = cyc;
    start_b = 1'b0;
  endtask

  task automatic wait_done_a(input int target, input int bound, output bit ok);
    int t = 0;
    while (done_n_a < target && t < bound) begin @(negedge clk); #1; t++; end
    ok = (done_n_a >= target);
  endtask

  task automatic wait_done_b(input int target, input int bound, output bit ok);
    int t = 0;
    while (done_n_b < target && t < bound) begin @(negedge clk); #1; t++; end
    ok = (done_n_b >= target);
  endtask

  task automatic load_hi(input int slot);
    mem_a[slot*SLOTLEN_A + 0] = 8'h48;
    mem_a[slot*SLOTLEN_A + 1] = 8'h69;
    mem_a[slot*SLOTLEN_A + 2] = 8'h00;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (oe_a !== 1'b0)    begin nerr++; $display("FAIL reset_oe: got %b want 0", oe_a); end
    nvec++; if (dout_a !== 8'h00) begin nerr++; $display("FAIL reset_dout: got %h want 00", dout_a); end
    nvec++; if (done_a !== 1'b0)  begin nerr++; $display("FAIL reset_done: got %b want 0", done_a); end
    nvec++; if (busy_a !== 1'b0)  begin nerr++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    nvec++; if (count_a !== 9'd0) begin nerr++; $display("FAIL reset_count: got %0d want 0", count_a); end
    nvec++; if (maddr_a !== 19'd0) begin nerr++; $display("FAIL reset_maddr: got %0d want 0", maddr_a); end
    nvec++; if ({oe_b, busy_b, done_b, count_b} !== 6'd0) begin
      nerr++; $display("FAIL reset_b: got oe=%b busy=%b done=%b count=%0d want all 0", oe_b, busy_b, done_b, count_b);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_hi();
    int n; bit ok;
    load_hi(1);
    rdy_mode_a = 0;
    clear_mon();
    pulse_start_a(2'd1, n);
    wait_done_a(1, 100, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL hi_done_timeout: got none want DONE"); end
    nvec++; if (got_a.size() != 2 || got_a[0] !== 8'h48 || got_a[1] !== 8'h69) begin
      nerr++; $display("FAIL hi_bytes: got %p want 48 69", got_a);
    end else begin
      nvec++; if (addr_a[0] != 256 || addr_a[1] != 257) begin
        nerr++; $display("FAIL hi_addr: got %0d %0d want 256 257", addr_a[0], addr_a[1]);
      end
      nvec++; if (xcyc_a[0] - n != 2) begin nerr++; $display("FAIL hi_first_latency: got %0d want 2", xcyc_a[0] - n); end
      nvec++; if (xcyc_a[1] - xcyc_a[0] != 3) begin nerr++; $display("FAIL hi_throughput: got %0d want 3", xcyc_a[1] - xcyc_a[0]); end
      nvec++; if (ok && dcyc_a[0] - xcyc_a[1] != 3) begin nerr++; $display("FAIL hi_done_delay: got %0d want 3", dcyc_a[0] - xcyc_a[1]); end
    end
    nvec++; if (maddr_a !== 19'd258) begin nerr++; $display("FAIL hi_term_addr: got %0d want 258", maddr_a); end
    nvec++; if (count_a !== 9'd2) begin nerr++; $display("FAIL hi_count: got %0d want 2", count_a); end
    repeat (3) @(negedge clk);
    nvec++; if (done_n_a != 1 || busy_a !== 1'b0) begin
      nerr++; $display("FAIL hi_single_done: got dones=%0d busy=%b want 1 0", done_n_a, busy_a);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure();
    int n, t, rcyc; bit ok;
    load_hi(1);
    rdy_mode_a = 2;
    clear_mon();
    pulse_start_a(2'd1, n);
    t = 0;
    while (oe_a !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    nvec++; if (oe_a !== 1'b1) begin nerr++; $display("FAIL bp_oe_timeout: got oe=%b want 1", oe_a); end
    for (int i = 0; i < 5; i++) begin
      nvec++; if (dout_a !== 8'h48 || count_a !== 9'd0 || oe_a !== 1'b1) begin
        nerr++; $display("FAIL bp_hold%0d: got dout=%h count=%0d oe=%b want 48 0 1", i, dout_a, count_a, oe_a);
      end
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    rdy_mode_a = 0;
    rcyc = cyc;
    wait_done_a(1, 100, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL bp_done_timeout: got none want DONE"); end
    nvec++; if (got_a.size() != 2 || got_a[0] !== 8'h48 || got_a[1] !== 8'h69) begin
      nerr++; $display("FAIL bp_bytes: got %p want 48 69", got_a);
    end else begin
      nvec++; if (xcyc_a[0] != rcyc) begin nerr++; $display("FAIL bp_xfer_cycle: got %0d want %0d", xcyc_a[0], rcyc); end
    end
    nvec++; if (count_a !== 9'd2) begin nerr++; $display("FAIL bp_count: got %0d want 2", count_a); end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_limit();
    int n; bit ok; bq_t exp;
    mem_b[0] = "A"; mem_b[1] = "B"; mem_b[2] = "C"; mem_b[3] = "D";
    mem_b[4] = "x"; mem_b[5] = "y"; mem_b[6] = "z"; mem_b[7] = 8'h00;
    rdy_mode_b = 0;
    clear_mon();
    pulse_start_b(2'd0, n);
    wait_done_b(1, 100, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL lim_done_timeout: got none want DONE"); end
    nvec++; if (got_b.size() != 4 || got_b[0] !== "A" || got_b[1] !== "B" || got_b[2] !== "C" || got_b[3] !== "D") begin
      nerr++; $display("FAIL lim_bytes: got %p want 41 42 43 44", got_b);
    end else begin
      nvec++; if (done_cyc_b - xcyc_b[3] != 1) begin nerr++; $display("FAIL lim_done_delay: got %0d want 1", done_cyc_b - xcyc_b[3]); end
    end
    nvec++; if (count_b !== 3'd4) begin nerr++; $display("FAIL lim_count: got %0d want 4", count_b); end
    nvec++; if (maxaddr_b != 3) begin nerr++; $display("FAIL lim_max_addr: got %0d want 3", maxaddr_b); end

    // Out-of-range select lands on the last slot; random contents there.
    for (int k = 0; k < SLOTLEN_B; k++) mem_b[8 + k] = 8'($urandom_range(1, 255));
    mem_b[8 + $urandom_range(1, 3)] = 8'h00;
    exp = ref_msg(1'b1, 2);
    rdy_mode_b = 1;
    clear_mon();
    pulse_start_b(2'd3, n);
    wait_done_b(1, 200, ok);
    nvec++; if (!ok || got_b != exp) begin
      nerr++; $display("FAIL clamp_bytes: got %p want %p", got_b, exp);
    end
    nvec++; if (int'(count_b) != exp.size()) begin nerr++; $display("FAIL clamp_count: got %0d want %0d", count_b, exp.size()); end
    rdy_mode_b = 0;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_empty_and_busy_start();
    int n, n2; bit ok;
    mem_a[2*SLOTLEN_A] = 8'h00;
    load_hi(1);
    rdy_mode_a = 0;
    clear_mon();
    pulse_start_a(2'd2, n);
    pulse_start_a(2'd1, n2);   // lands while busy: must be ignored
    wait_done_a(1, 50, ok);
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (!ok) begin nerr++; $display("FAIL empty_done_timeout: got none want DONE"); end
    else begin
      nvec++; if (dcyc_a[0] - n != 2) begin nerr++; $display("FAIL empty_done_latency: got %0d want 2", dcyc_a[0] - n); end
    end
    nvec++; if (done_n_a != 1) begin nerr++; $display("FAIL empty_done_count: got %0d want 1", done_n_a); end
    nvec++; if (oe_seen_a) begin nerr++; $display("FAIL empty_oe: got 1 want 0"); end
    nvec++; if (count_a !== 9'd0 || busy_a !== 1'b0) begin
      nerr++; $display("FAIL empty_final: got count=%0d busy=%b want 0 0", count_a, busy_a);
    end

    clear_mon();
    pulse_start_a(2'd1, n);
    pulse_start_a(2'd3, n2);
    wait_done_a(1, 100, ok);
    repeat (10) @(negedge clk);
    #1;
    nvec++; if (!ok || got_a.size() != 2 || got_a[0] !== 8'h48 || got_a[1] !== 8'h69 || done_n_a != 1) begin
      nerr++; $display("FAIL busy_start_ignored: got %p dones=%0d want 48 69 and 1", got_a, done_n_a);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset_mid();
    int n, t; bit ok;
    load_hi(1);
    rdy_mode_a = 0;
    clear_mon();
    pulse_start_a(2'd1, n);
    t = 0;
    while (got_a.size() < 1 && t < 20) begin @(negedge clk); #1; t++; end
    @(posedge clk); #1;
    rdy_mode_a = 2;
    t = 0;
    while (oe_a !== 1'b1 && t < 20) begin @(negedge clk); #1; t++; end
    nvec++; if (oe_a !== 1'b1 || count_a !== 9'd1) begin
      nerr++; $display("FAIL rmid_setup: got oe=%b count=%0d want 1 1", oe_a, count_a);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    nvec++; if (oe_a !== 1'b0 || busy_a !== 1'b0 || count_a !== 9'd0) begin
      nerr++; $display("FAIL rmid_async: got oe=%b busy=%b count=%0d want 0 0 0", oe_a, busy_a, count_a);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rdy_mode_a = 0;
    repeat (5) @(negedge clk);
    nvec++; if (done_n_a != 0) begin nerr++; $display("FAIL rmid_no_done: got %0d want 0", done_n_a); end
    clear_mon();
    pulse_start_a(2'd1, n);
    wait_done_a(1, 100, ok);
    nvec++; if (!ok || got_a.size() != 2 || got_a[0] !== 8'h48 || got_a[1] !== 8'h69 || count_a !== 9'd2) begin
      nerr++; $display("FAIL rmid_restart: got %p count=%0d want 48 69 count 2", got_a, count_a);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int slot, len, n; bit ok; bq_t exp;
      slot = $urandom_range(0, NSLOTS_A - 1);
      len  = (it == 0) ? SLOTLEN_A : (it == 1) ? 0 : $urandom_range(1, 12);
      for (int k = 0; k < SLOTLEN_A; k++)
        mem_a[slot*SLOTLEN_A + k] = (k < len) ? 8'($urandom_range(1, 255)) : 8'($urandom_range(0, 255));
      if (len < SLOTLEN_A) mem_a[slot*SLOTLEN_A + len] = 8'h00;
      exp = ref_msg(1'b0, slot);
      rdy_mode_a = 1;
      clear_mon();
      pulse_start_a(2'(slot), n);
      wait_done_a(1, 4000, ok);
      nvec++; if (!ok) begin nerr++; $display("FAIL rnd%0d_timeout: got none want DONE", it); end
      nvec++; if (got_a.size() != exp.size()) begin
        nerr++; $display("FAIL rnd%0d_len: got %0d want %0d", it, got_a.size(), exp.size());
      end else begin
        for (int k = 0; k < exp.size(); k++) begin
          nvec++; if (got_a[k] !== exp[k] || addr_a[k] != slot*SLOTLEN_A + k) begin
            nerr++; $display("FAIL rnd%0d_byte%0d: got %h@%0d want %h@%0d", it, k, got_a[k], addr_a[k], exp[k], slot*SLOTLEN_A + k);
          end
        end
        if (ok) begin
          nvec++;
          if (exp.size() == 0) begin
            if (dcyc_a[0] - n != 2) begin nerr++; $display("FAIL rnd%0d_done_delay: got %0d want 2", it, dcyc_a[0] - n); end
          end else if (exp.size() == SLOTLEN_A) begin
            if (dcyc_a[0] - xcyc_a[$] != 1) begin nerr++; $display("FAIL rnd%0d_done_delay: got %0d want 1", it, dcyc_a[0] - xcyc_a[$]); end
          end else begin
            if (dcyc_a[0] - xcyc_a[$] != 3) begin nerr++; $display("FAIL rnd%0d_done_delay: got %0d want 3", it, dcyc_a[0] - xcyc_a[$]); end
          end
        end
      end
      nvec++; if (int'(count_a) != exp.size()) begin
        nerr++; $display("FAIL rnd%0d_count: got %0d want %0d", it, count_a, exp.size());
      end
    end
    rdy_mode_a = 0;
  endtask

`ifdef MSG_STREAMER_LOOP_EN
  // --------------------------------------------------------------------------
  task automatic test_loop();
    int n, t; bit ok;
    load_hi(1);
    rdy_mode_a = 0;
    clear_mon();
    loop_a = 1'b1;
    pulse_start_a(2'd1, n);
    wait_done_a(3, 200, ok);
    @(posedge clk); #1;
    loop_a = 1'b0;
    t = 0;
    while (busy_a !== 1'b0 && t < 100) begin @(negedge clk); #1; t++; end
    nvec++; if (busy_a !== 1'b0 || done_n_a != 4) begin
      nerr++; $display("FAIL loop_stop: got busy=%b dones=%0d want 0 4", busy_a, done_n_a);
    end
    nvec++; if (got_a.size() != 8) begin
      nerr++; $display("FAIL loop_len: got %0d want 8", got_a.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        nvec++; if (got_a[k] !== ((k % 2 == 0) ? 8'h48 : 8'h69)) begin
          nerr++; $display("FAIL loop_byte%0d: got %h want %h", k, got_a[k], (k % 2 == 0) ? 8'h48 : 8'h69);
        end
      end
    end

    mem_a[2*SLOTLEN_A] = 8'h00;
    clear_mon();
    loop_a = 1'b1;
    pulse_start_a(2'd2, n);
    wait_done_a(3, 50, ok);
    @(posedge clk); #1;
    loop_a = 1'b0;
    repeat (10) @(negedge clk);
    nvec++; if (!ok || dcyc_a[1] - dcyc_a[0] != 3 || dcyc_a[2] - dcyc_a[1] != 3 || oe_seen_a) begin
      nerr++; $display("FAIL loop_empty: got dones=%p oe_seen=%0d want period 3 and no oe", dcyc_a, oe_seen_a);
    end
  endtask
`endif

  // --------------------------------------------------------------------------
  initial begin
    for (int k = 0; k < NSLOTS_A*SLOTLEN_A; k++) mem_a[k] = 8'($urandom_range(1, 255));
    for (int k = 0; k < NSLOTS_B*SLOTLEN_B; k++) mem_b[k] = 8'($urandom_range(1, 255));
    test_reset();
    test_hi();
    test_backpressure();
    test_limit();
    test_empty_and_busy_start();
    test_reset_mid();
    test_random();
`ifdef MSG_STREAMER_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
